// File: rtl/branch_predictor_if.sv
// Fetch/resolve-side bundle for the branch target buffer: lookup, training and stats.
// No latency of its own; the predictor answers lookups combinationally.
// No backpressure: updates are single-cycle strobes that are always accepted unless flushed.
interface branch_predictor_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  flush;
    logic [ADDR_WIDTH-1:0] lookup_addr;
    logic                  pred_taken;
    logic [ADDR_WIDTH-1:0] pred_addr;
    logic                  update_en;
    logic [ADDR_WIDTH-1:0] update_addr;
    logic                  update_taken;
    logic [ADDR_WIDTH-1:0] update_target;
    logic                  update_uncond;
    logic [15:0]           hit_count;
    logic [15:0]           update_count;

    modport master (
        output flush, lookup_addr, update_en, update_addr, update_taken,
               update_target, update_uncond,
        input  pred_taken, pred_addr, hit_count, update_count
    );

    modport slave (
        input  flush, lookup_addr, update_en, update_addr, update_taken,
               update_target, update_uncond,
        output pred_taken, pred_addr, hit_count, update_count
    );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit saturating direction counters, trained from ID resolution.
// Latency: lookup is zero-cycle combinational; updates become visible the cycle after the edge.
// Backpressure: none; flush drops any same-cycle update.
module branch_predictor #(
    parameter int          ADDR_WIDTH   = 32,
    parameter int          ENTRY_NUM    = 64,
    parameter logic [1:0]  COUNTER_INIT = 2'b10
) (
    input  logic             clk,
    input  logic             rst,
    branch_predictor_if.slave bp
);
    localparam int IDX_BITS = $clog2(ENTRY_NUM);
    localparam int TAG_BITS = ADDR_WIDTH - IDX_BITS - 2;

    logic [ENTRY_NUM-1:0]  valid_q, valid_d;
    logic [1:0]            cnt_q [ENTRY_NUM];
    logic [1:0]            cnt_d [ENTRY_NUM];
    logic [TAG_BITS-1:0]   tag_q [ENTRY_NUM];
    logic [TAG_BITS-1:0]   tag_d [ENTRY_NUM];
    logic [ADDR_WIDTH-1:0] tgt_q [ENTRY_NUM];
    logic [ADDR_WIDTH-1:0] tgt_d [ENTRY_NUM];
    logic [15:0]           hit_cnt_q, hit_cnt_d;
    logic [15:0]           upd_cnt_q, upd_cnt_d;

    logic [IDX_BITS-1:0]   lk_idx, up_idx;
    logic [TAG_BITS-1:0]   lk_tag, up_tag;
    logic                  lk_hit, up_hit, up_taken;
    logic                  unused_addr_lsbs;

    assign lk_idx = bp.lookup_addr[IDX_BITS+1:2];
    assign lk_tag = bp.lookup_addr[ADDR_WIDTH-1:IDX_BITS+2];
    assign up_idx = bp.update_addr[IDX_BITS+1:2];
    assign up_tag = bp.update_addr[ADDR_WIDTH-1:IDX_BITS+2];
    assign unused_addr_lsbs = ^{bp.lookup_addr[1:0], bp.update_addr[1:0]};

    // Lookup reads registered state only, so a same-cycle update is not bypassed.
    assign lk_hit        = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    assign bp.pred_taken = lk_hit && cnt_q[lk_idx][1];
    assign bp.pred_addr  = bp.pred_taken ? tgt_q[lk_idx] : '0;

    assign up_hit   = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
    assign up_taken = bp.update_taken || bp.update_uncond;

    assign bp.hit_count    = hit_cnt_q;
    assign bp.update_count = upd_cnt_q;

    always_comb begin
        valid_d   = valid_q;
        cnt_d     = cnt_q;
        tag_d     = tag_q;
        tgt_d     = tgt_q;
        hit_cnt_d = hit_cnt_q;
        upd_cnt_d = upd_cnt_q;

        if (bp.pred_taken && !bp.flush) begin
            hit_cnt_d = hit_cnt_q + 16'd1;
        end

        if (bp.flush) begin
            valid_d = '0;
        end else if (bp.update_en) begin
            upd_cnt_d = upd_cnt_q + 16'd1;
            if (up_hit) begin
                if (up_taken) begin
                    tgt_d[up_idx] = bp.update_target;
                    cnt_d[up_idx] = (bp.update_uncond || cnt_q[up_idx] == 2'b11)
                                    ? 2'b11 : cnt_q[up_idx] + 2'd1;
                end else begin
                    cnt_d[up_idx] = (cnt_q[up_idx] == 2'b00) ? 2'b00 : cnt_q[up_idx] - 2'd1;
                end
            end else if (up_taken) begin
                // Direct-mapped: a taken miss evicts whatever owns this index.
                valid_d[up_idx] = 1'b1;
                tag_d[up_idx]   = up_tag;
                tgt_d[up_idx]   = bp.update_target;
                cnt_d[up_idx]   = bp.update_uncond ? 2'b11 : COUNTER_INIT;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q   <= '0;
            hit_cnt_q <= '0;
            upd_cnt_q <= '0;
            for (int i = 0; i < ENTRY_NUM; i++) begin
                cnt_q[i] <= COUNTER_INIT;
                tag_q[i] <= '0;
                tgt_q[i] <= '0;
            end
        end else begin
            valid_q   <= valid_d;
            cnt_q     <= cnt_d;
            tag_q     <= tag_d;
            tgt_q     <= tgt_d;
            hit_cnt_q <= hit_cnt_d;
            upd_cnt_q <= upd_cnt_d;
        end
    end
endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: expected predictions queued at drive time, popped at check.
module tb_branch_predictor;
    localparam logic [31:0] IDLE = 32'h0000_0000;
    localparam logic [31:0] A    = 32'h0040_0010;
    localparam logic [31:0] B    = 32'h0040_0110;
    localparam logic [31:0] C    = 32'h0040_0020;
    localparam logic [31:0] D    = 32'h0040_0030;
    localparam logic [31:0] T1   = 32'h0040_0100;
    localparam logic [31:0] T2   = 32'h0040_0200;
    localparam logic [31:0] T3   = 32'h0040_0300;
    localparam logic [31:0] T4   = 32'h0040_0400;
    localparam logic [31:0] T5   = 32'h0040_0500;

    typedef struct {
        logic        taken;
        logic [31:0] addr;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   tests = 0;
    int   fails = 0;
    logic [15:0] exp_hits = '0;
    logic [15:0] exp_upds = '0;
    exp_t exp_q [$];

    branch_predictor_if #(.ADDR_WIDTH(32)) bp ();

    branch_predictor #(
        .ADDR_WIDTH  (32),
        .ENTRY_NUM   (64),
        .COUNTER_INIT(2'b10)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bp (bp)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic chk_counts(input string tag);
        chk({tag, ".hit_count"}, {16'd0, bp.hit_count}, {16'd0, exp_hits});
        chk({tag, ".update_count"}, {16'd0, bp.update_count}, {16'd0, exp_upds});
    endtask

    // One cycle: drive at negedge, check just after, inputs held through the next posedge.
    task automatic step(input string tag, input logic [31:0] la,
                        input logic ue, input logic [31:0] ua, input logic ut,
                        input logic [31:0] utgt, input logic uu, input logic fl,
                        input logic et, input logic [31:0] ea);
        exp_t e;
        exp_t o;
        @(negedge clk);
        e.taken = et;
        e.addr  = ea;
        exp_q.push_back(e);
        bp.lookup_addr   = la;
        bp.update_en     = ue;
        bp.update_addr   = ua;
        bp.update_taken  = ut;
        bp.update_target = utgt;
        bp.update_uncond = uu;
        bp.flush         = fl;
        #1;
        chk_counts(tag);
        o = exp_q.pop_front();
        chk({tag, ".pred_taken"}, {31'd0, bp.pred_taken}, {31'd0, o.taken});
        chk({tag, ".pred_addr"}, bp.pred_addr, o.addr);
        if (et && !fl) exp_hits++;
        if (ue && !fl) exp_upds++;
    endtask

    task automatic look(input string tag, input logic [31:0] la, input logic et, input logic [31:0] ea);
        step(tag, la, 1'b0, IDLE, 1'b0, IDLE, 1'b0, 1'b0, et, ea);
    endtask

    task automatic upd(input string tag, input logic [31:0] ua, input logic ut,
                       input logic [31:0] utgt, input logic uu);
        step(tag, IDLE, 1'b1, ua, ut, utgt, uu, 1'b0, 1'b0, IDLE);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst              = 1'b0;
        bp.flush         = 1'b0;
        bp.lookup_addr   = IDLE;
        bp.update_en     = 1'b0;
        bp.update_addr   = IDLE;
        bp.update_taken  = 1'b0;
        bp.update_target = IDLE;
        bp.update_uncond = 1'b0;

        look("reset_look", 32'h0040_0000, 1'b0, IDLE);
        rst = 1'b1;

        upd ("alloc_A", A, 1'b1, T1, 1'b0);
        look("hit_A", A, 1'b1, T1);
        upd ("nt1", A, 1'b0, IDLE, 1'b0);
        look("look_A_01", A, 1'b0, IDLE);
        step("nt2", A, 1'b1, A, 1'b0, IDLE, 1'b0, 1'b0, 1'b0, IDLE);
        step("nt3_sat", A, 1'b1, A, 1'b0, IDLE, 1'b0, 1'b0, 1'b0, IDLE);
        step("t1", A, 1'b1, A, 1'b1, T1, 1'b0, 1'b0, 1'b0, IDLE);
        step("t2", A, 1'b1, A, 1'b1, T2, 1'b0, 1'b0, 1'b0, IDLE);
        look("look_A_retrained", A, 1'b1, T2);

        upd ("miss_nt_C", C, 1'b0, IDLE, 1'b0);
        look("look_C_noalloc", C, 1'b0, IDLE);

        upd ("alias_B", B, 1'b1, T3, 1'b0);
        look("look_A_evicted", A, 1'b0, IDLE);
        look("look_B", B, 1'b1, T3);
        upd ("alias_nt_A", A, 1'b0, IDLE, 1'b0);
        look("look_B_kept", B, 1'b1, T3);

        step("same_cycle_D", D, 1'b1, D, 1'b1, T4, 1'b0, 1'b0, 1'b0, IDLE);
        look("look_D", D, 1'b1, T4);

        step("flush", D, 1'b1, C, 1'b1, T5, 1'b0, 1'b1, 1'b1, T4);
        look("look_D_flushed", D, 1'b0, IDLE);
        look("look_B_flushed", B, 1'b0, IDLE);
        look("look_C_dropped", C, 1'b0, IDLE);

        upd ("jal_C", C, 1'b1, T5, 1'b1);
        upd ("jal_nt", C, 1'b0, IDLE, 1'b0);
        look("look_C_jal", C, 1'b1, T5);

        // Asynchronous reset pulse entirely between two clock edges.
        @(negedge clk);
        bp.lookup_addr = C;
        #1;
        chk("pre_rst.pred_taken", {31'd0, bp.pred_taken}, 32'd1);
        chk_counts("pre_rst");
        rst = 1'b0;
        #1;
        exp_hits = '0;
        exp_upds = '0;
        chk("async_rst.pred_taken", {31'd0, bp.pred_taken}, 32'd0);
        chk("async_rst.pred_addr", bp.pred_addr, 32'd0);
        chk_counts("async_rst");
        #1;
        rst = 1'b1;
        look("post_rst_C", C, 1'b0, IDLE);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
